rs_alu_station: RTL
===================

// Module: rs_alu_station
// PURPOSE
//  Parametrised ALU reservation station: holds dispatched ALU/branch/JALR/LUI/AUIPC/JAL ops until their
//  operands are ready, snoops NUM_CDB result buses, and issues oldest-ready first to one ALU port.
//  Sits between dispatcher and ALU; loads/stores go to the separate LS path. Tag 0 means operand ready.
// PARAMETERS
//  DEPTH     8   entries (>=2)
//  NUM_CDB   2   CDB wake-up channels (>=1)
//  TAG_W     4   ROB tag width; tag 0 reserved as "no dependency"
//  DATA_W    32  operand/immediate width
//  ADDR_W    32  PC width
//  OP_W      6   opcode width (InstType encoding)
// PORTS
//  clk_in          in   1               clock
//  rst_in          in   1               synchronous reset, active-high
//  rdy_in          in   1               global enable; 0 freezes all state
//  flush_in        in   1               mispredict flush from ROB
//  disp_valid_in   in   1               dispatch request
//  disp_ready_out  out  1               >=1 free entry
//  disp_{qj,qk}_in in   TAG_W           source tags (0 = value valid)
//  disp_{vj,vk}_in in   DATA_W          source values
//  disp_a_in       in   DATA_W          immediate
//  disp_dest_in    in   TAG_W           destination ROB tag
//  disp_pc_in      in   ADDR_W          instruction PC
//  disp_opcode_in  in   OP_W            opcode
//  cdb_valid_in    in   NUM_CDB         per-channel broadcast valid
//  cdb_tag_in      in   NUM_CDB*TAG_W   flattened tags, channel 0 in LSBs
//  cdb_data_in     in   NUM_CDB*DATA_W  flattened results
//  issue_valid_out out  1               issue register holds an op
//  issue_ready_in  in   1               ALU accepts
//  issue_{a,vj,vk}_out out DATA_W       operands
//  issue_dest_out  out  TAG_W ; issue_pc_out out ADDR_W ; issue_opcode_out out OP_W (NOP when idle)
//  count_out       out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset (rst_in=1 at posedge): all entries invalid, age matrix cleared, issue_valid_out=0,
//    issue_opcode_out=NOP, other issue outputs 0, count_out=0, disp_ready_out=1 next cycle.
//  - rdy_in=0: no state change, outputs hold; rst_in overrides rdy_in.
//  - Dispatch: accepted iff disp_valid_in & disp_ready_out; written to lowest-index free entry.
//    disp_ready_out depends only on registered state (no combinational path from disp_valid_in).
//  - Dispatch-cycle CDB capture mandatory: if disp_qj/qk matches a valid CDB tag that cycle, entry
//    stores the CDB value with tag 0.
//  - Wake-up: each valid entry compares qj,qk with every valid nonzero CDB tag; on match take data,
//    clear tag. Several channels matching: lowest channel index wins.
//  - Readiness: R/B-type need qj=qk=0; I-type/JALR need qj=0; LUI/AUIPC/JAL always ready.
//  - Issue register loads when !issue_valid_out | issue_ready_in: oldest ready entry (age matrix,
//    older = dispatched earlier) is copied and freed same edge; none ready -> issue_valid_out=0.
//    Latency dispatch->issue_valid_out = 2 cycles for a ready op into empty station.
//  - Entry freed this edge is not reallocated until the next cycle. count_out = valid entries,
//    excluding issue register. Full: disp_ready_out=0, further dispatches ignored.
//  - Stall: issue_valid_out & !issue_ready_in holds all issue outputs stable.
//  - flush_in: next edge clears all entries and issue register (as reset); same-cycle dispatch and
//    issue handshake discarded.
// CONFIGURATION
//  RS_WAKEUP_ISSUE_EN defined: selection uses post-wake-up readiness, so an entry woken by a CDB
//  this cycle can be issued this edge with the forwarded CDB value (back-to-back dependents).
//  Undefined: selection uses registered tags only; woken entry issues earliest next cycle.
// STRUCTURE
//  Package rs_pkg: opcode constants/ranges (NOP, LUI..JAL, BEQ..BGEU, ADDI..SRAI, ADD..AND),
//  is_rtype/is_itype/is_noreg helper functions, TAG_NONE=0.
//  Sub-module rs_age_select: DEPTH x DEPTH age matrix, update on alloc/free, one-hot oldest-ready
//  grant from ready vector. Free-entry pick is a priority encoder in the top.
// TESTING
//  1 ADDI qj=0 dispatched into empty RS, issue_ready_in=1 -> issue_valid_out cycle+2, vj/a match.
//  2 ADD qj=3 qk=0; cdb tag3=0x55 on ch1 two cycles later -> issues vj=0x55; with RS_WAKEUP_ISSUE_EN
//    one cycle earlier than without.
//  3 Fill DEPTH entries all waiting tag5 -> disp_ready_out=0, 9th dispatch dropped; broadcast tag5
//    -> issues in dispatch order, one per cycle, count_out decrements to 0.
//  4 issue_ready_in=0 for 4 cycles with 2 ready ops -> outputs stable, then second issues after accept.
//  5 Dispatch qj=7 same cycle CDB ch0 tag7=0xAB -> entry captured ready, issues vj=0xAB.
//  6 flush_in with 5 entries and pending issue -> next cycle issue_valid_out=0, count_out=0,
//    simultaneous dispatch absent; rdy_in=0 mid-run freezes everything.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode encoding,
// operand-readiness classification helpers and the "no dependency" tag.
package rs_pkg;

    localparam int OPC_W    = 6;
    localparam int TAG_NONE = 0;

    // Opcode encoding; loads/stores occupy 11..18 and never reach this station.
    localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OPC_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OPC_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OPC_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OPC_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OPC_W-1:0] OP_ADD   = 6'd28;
    localparam logic [OPC_W-1:0] OP_AND   = 6'd37;

    // Branches and register-register ALU ops read both sources.
    function automatic logic is_rtype(input logic [OPC_W-1:0] op);
        return ((op >= OP_BEQ) && (op <= OP_BGEU)) || ((op >= OP_ADD) && (op <= OP_AND));
    endfunction

    // Immediate ALU ops and JALR read rs1 only.
    function automatic logic is_itype(input logic [OPC_W-1:0] op);
        return ((op >= OP_ADDI) && (op <= OP_SRAI)) || (op == OP_JALR);
    endfunction

    // LUI/AUIPC/JAL read no register.
    function automatic logic is_noreg(input logic [OPC_W-1:0] op);
        return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL);
    endfunction

    // Operand readiness given which source tags are already resolved.
    function automatic logic op_ready(input logic [OPC_W-1:0] op,
                                      input logic qj_zero,
                                      input logic qk_zero);
        logic rdy;
        if (is_noreg(op)) begin
            rdy = 1'b1;
        end else if (is_itype(op)) begin
            rdy = qj_zero;
        end else begin
            rdy = qj_zero & qk_zero;
        end
        return rdy;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station: tracks relative dispatch order of
// entries and grants the oldest ready entry (one-hot).
module rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             clr_in,
    input  logic [DEPTH-1:0] alloc_in,
    input  logic [DEPTH-1:0] ready_in,
    output logic [DEPTH-1:0] grant_out
);

    // older_r[i][j] = 1 means entry i was dispatched before entry j.
    logic [DEPTH-1:0] older_r [DEPTH];
    logic [DEPTH-1:0] blocked_s;

    // Newly allocated entry becomes younger than every other entry.
    always_ff @(posedge clk_in) begin
        if (rst_in || (en_in && clr_in)) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= {DEPTH{1'b0}};
            end
        end else if (en_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_in[j] && (i != j)) begin
                        older_r[i][j] <= 1'b1;
                    end else if (alloc_in[i]) begin
                        older_r[i][j] <= 1'b0;
                    end else begin
                        older_r[i][j] <= older_r[i][j];
                    end
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                older_r[i] <= older_r[i];
            end
        end
    end

    // An entry wins when it is ready and no older entry is ready.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            blocked_s[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s[i] = blocked_s[i] | (ready_in[j] & older_r[j][i]);
            end
            grant_out[i] = ready_in[i] & ~blocked_s[i];
        end
    end

endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation station: buffers dispatched ALU/branch/jump ops, snoops the
// CDB for missing operands, and issues the oldest ready op to one ALU port.
// Optional build macro RS_WAKEUP_ISSUE_EN: selection sees this cycle's CDB
// wake-ups so dependents issue back-to-back; otherwise selection uses only
// registered tags.
module rs_alu_station
    import rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int OP_W    = 6,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      disp_valid_in,
    output logic                      disp_ready_out,
    input  logic [TAG_W-1:0]          disp_qj_in,
    input  logic [TAG_W-1:0]          disp_qk_in,
    input  logic [DATA_W-1:0]         disp_vj_in,
    input  logic [DATA_W-1:0]         disp_vk_in,
    input  logic [DATA_W-1:0]         disp_a_in,
    input  logic [TAG_W-1:0]          disp_dest_in,
    input  logic [ADDR_W-1:0]         disp_pc_in,
    input  logic [OP_W-1:0]           disp_opcode_in,
    input  logic [NUM_CDB-1:0]        cdb_valid_in,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_in,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_in,
    output logic                      issue_valid_out,
    input  logic                      issue_ready_in,
    output logic [DATA_W-1:0]         issue_a_out,
    output logic [DATA_W-1:0]         issue_vj_out,
    output logic [DATA_W-1:0]         issue_vk_out,
    output logic [TAG_W-1:0]          issue_dest_out,
    output logic [ADDR_W-1:0]         issue_pc_out,
    output logic [OP_W-1:0]           issue_opcode_out,
    output logic [CNT_W-1:0]          count_out
);

    // Entry storage
    logic [DEPTH-1:0]  valid_r;
    logic [TAG_W-1:0]  qj_r   [DEPTH];
    logic [TAG_W-1:0]  qk_r   [DEPTH];
    logic [DATA_W-1:0] vj_r   [DEPTH];
    logic [DATA_W-1:0] vk_r   [DEPTH];
    logic [DATA_W-1:0] a_r    [DEPTH];
    logic [TAG_W-1:0]  dest_r [DEPTH];
    logic [ADDR_W-1:0] pc_r   [DEPTH];
    logic [OP_W-1:0]   op_r   [DEPTH];

    // Issue register
    logic              issue_valid_r;
    logic [DATA_W-1:0] issue_a_r;
    logic [DATA_W-1:0] issue_vj_r;
    logic [DATA_W-1:0] issue_vk_r;
    logic [TAG_W-1:0]  issue_dest_r;
    logic [ADDR_W-1:0] issue_pc_r;
    logic [OP_W-1:0]   issue_op_r;

    // Post-wake-up operand view
    logic [TAG_W-1:0]  qj_w_s [DEPTH];
    logic [TAG_W-1:0]  qk_w_s [DEPTH];
    logic [DATA_W-1:0] vj_w_s [DEPTH];
    logic [DATA_W-1:0] vk_w_s [DEPTH];
    logic [DATA_W:0]   hj_s   [DEPTH];
    logic [DATA_W:0]   hk_s   [DEPTH];
    logic [DATA_W:0]   disp_hj_s;
    logic [DATA_W:0]   disp_hk_s;

    logic [DEPTH-1:0]  free_s;
    logic [DEPTH-1:0]  alloc_oh_s;
    logic [DEPTH-1:0]  age_alloc_s;
    logic [DEPTH-1:0]  ready_s;
    logic [DEPTH-1:0]  grant_s;
    logic              disp_fire_s;
    logic              issue_load_s;
    logic [CNT_W-1:0]  cnt_s;

    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_vj_s;
    logic [DATA_W-1:0] sel_vk_s;
    logic [TAG_W-1:0]  sel_dest_s;
    logic [ADDR_W-1:0] sel_pc_s;
    logic [OP_W-1:0]   sel_op_s;

    // CDB snoop: {hit, data}; iterating high-to-low lets the lowest channel win.
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0]          tag,
                                              input logic [NUM_CDB-1:0]        vld,
                                              input logic [NUM_CDB*TAG_W-1:0]  tags,
                                              input logic [NUM_CDB*DATA_W-1:0] data);
        logic [DATA_W:0] res;
        res = {1'b0, {DATA_W{1'b0}}};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && (tag != TAG_W'(TAG_NONE)) && (tag == tags[c*TAG_W +: TAG_W])) begin
                res = {1'b1, data[c*DATA_W +: DATA_W]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Wake-up: forward matching CDB results into each entry's operands.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hj_s[i] = snoop(qj_r[i], cdb_valid_in, cdb_tag_in, cdb_data_in);
            hk_s[i] = snoop(qk_r[i], cdb_valid_in, cdb_tag_in, cdb_data_in);
            if (hj_s[i][DATA_W]) begin
                qj_w_s[i] = TAG_W'(TAG_NONE);
                vj_w_s[i] = hj_s[i][DATA_W-1:0];
            end else begin
                qj_w_s[i] = qj_r[i];
                vj_w_s[i] = vj_r[i];
            end
            if (hk_s[i][DATA_W]) begin
                qk_w_s[i] = TAG_W'(TAG_NONE);
                vk_w_s[i] = hk_s[i][DATA_W-1:0];
            end else begin
                qk_w_s[i] = qk_r[i];
                vk_w_s[i] = vk_r[i];
            end
        end
        disp_hj_s = snoop(disp_qj_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
        disp_hk_s = snoop(disp_qk_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
    end

    // Readiness per entry; the macro chooses pre- or post-wake-up tags.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_ISSUE_EN
            ready_s[i] = valid_r[i] & op_ready(OPC_W'(op_r[i]),
                                               qj_w_s[i] == TAG_W'(TAG_NONE),
                                               qk_w_s[i] == TAG_W'(TAG_NONE));
`else
            ready_s[i] = valid_r[i] & op_ready(OPC_W'(op_r[i]),
                                               qj_r[i] == TAG_W'(TAG_NONE),
                                               qk_r[i] == TAG_W'(TAG_NONE));
`endif
        end
    end

    // Free-slot priority pick, handshakes and occupancy, all from registered state.
    always_comb begin
        free_s       = ~valid_r;
        alloc_oh_s   = free_s & (~free_s + DEPTH'(1));
        disp_fire_s  = disp_valid_in & (|free_s) & rdy_in & ~flush_in;
        age_alloc_s  = disp_fire_s ? alloc_oh_s : {DEPTH{1'b0}};
        issue_load_s = ~issue_valid_r | issue_ready_in;
        cnt_s        = {CNT_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt_s = cnt_s + CNT_W'(valid_r[i]);
        end
    end

    // One-hot mux of the granted entry's fields (with forwarded operands).
    always_comb begin
        sel_a_s    = {DATA_W{1'b0}};
        sel_vj_s   = {DATA_W{1'b0}};
        sel_vk_s   = {DATA_W{1'b0}};
        sel_dest_s = {TAG_W{1'b0}};
        sel_pc_s   = {ADDR_W{1'b0}};
        sel_op_s   = {OP_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            sel_a_s    = sel_a_s    | (a_r[i]    & {DATA_W{grant_s[i]}});
            sel_vj_s   = sel_vj_s   | (vj_w_s[i] & {DATA_W{grant_s[i]}});
            sel_vk_s   = sel_vk_s   | (vk_w_s[i] & {DATA_W{grant_s[i]}});
            sel_dest_s = sel_dest_s | (dest_r[i] & {TAG_W{grant_s[i]}});
            sel_pc_s   = sel_pc_s   | (pc_r[i]   & {ADDR_W{grant_s[i]}});
            sel_op_s   = sel_op_s   | (op_r[i]   & {OP_W{grant_s[i]}});
        end
    end

    rs_age_select #(
        .DEPTH(DEPTH)
    ) u_age (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_in    (rdy_in),
        .clr_in   (flush_in),
        .alloc_in (age_alloc_s),
        .ready_in (ready_s),
        .grant_out(grant_s)
    );

    // Entry allocation, wake-up, release and issue-register update.
    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush_in)) begin
            valid_r       <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                qj_r[i]   <= {TAG_W{1'b0}};
                qk_r[i]   <= {TAG_W{1'b0}};
                vj_r[i]   <= {DATA_W{1'b0}};
                vk_r[i]   <= {DATA_W{1'b0}};
                a_r[i]    <= {DATA_W{1'b0}};
                dest_r[i] <= {TAG_W{1'b0}};
                pc_r[i]   <= {ADDR_W{1'b0}};
                op_r[i]   <= OP_W'(OP_NOP);
            end
            issue_valid_r <= 1'b0;
            issue_a_r     <= {DATA_W{1'b0}};
            issue_vj_r    <= {DATA_W{1'b0}};
            issue_vk_r    <= {DATA_W{1'b0}};
            issue_dest_r  <= {TAG_W{1'b0}};
            issue_pc_r    <= {ADDR_W{1'b0}};
            issue_op_r    <= OP_W'(OP_NOP);
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire_s && alloc_oh_s[i]) begin
                    valid_r[i] <= 1'b1;
                    qj_r[i]    <= disp_hj_s[DATA_W] ? TAG_W'(TAG_NONE) : disp_qj_in;
                    vj_r[i]    <= disp_hj_s[DATA_W] ? disp_hj_s[DATA_W-1:0] : disp_vj_in;
                    qk_r[i]    <= disp_hk_s[DATA_W] ? TAG_W'(TAG_NONE) : disp_qk_in;
                    vk_r[i]    <= disp_hk_s[DATA_W] ? disp_hk_s[DATA_W-1:0] : disp_vk_in;
                    a_r[i]     <= disp_a_in;
                    dest_r[i]  <= disp_dest_in;
                    pc_r[i]    <= disp_pc_in;
                    op_r[i]    <= disp_opcode_in;
                end else if (valid_r[i]) begin
                    valid_r[i] <= ~(issue_load_s & grant_s[i]);
                    qj_r[i]    <= qj_w_s[i];
                    vj_r[i]    <= vj_w_s[i];
                    qk_r[i]    <= qk_w_s[i];
                    vk_r[i]    <= vk_w_s[i];
                end else begin
                    valid_r[i] <= 1'b0;
                end
            end
            if (issue_load_s && (|grant_s)) begin
                issue_valid_r <= 1'b1;
                issue_a_r     <= sel_a_s;
                issue_vj_r    <= sel_vj_s;
                issue_vk_r    <= sel_vk_s;
                issue_dest_r  <= sel_dest_s;
                issue_pc_r    <= sel_pc_s;
                issue_op_r    <= sel_op_s;
            end else if (issue_load_s) begin
                issue_valid_r <= 1'b0;
                issue_a_r     <= {DATA_W{1'b0}};
                issue_vj_r    <= {DATA_W{1'b0}};
                issue_vk_r    <= {DATA_W{1'b0}};
                issue_dest_r  <= {TAG_W{1'b0}};
                issue_pc_r    <= {ADDR_W{1'b0}};
                issue_op_r    <= OP_W'(OP_NOP);
            end else begin
                issue_valid_r <= issue_valid_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign disp_ready_out   = |free_s;
    assign count_out        = cnt_s;
    assign issue_valid_out  = issue_valid_r;
    assign issue_a_out      = issue_a_r;
    assign issue_vj_out     = issue_vj_r;
    assign issue_vk_out     = issue_vk_r;
    assign issue_dest_out   = issue_dest_r;
    assign issue_pc_out     = issue_pc_r;
    assign issue_opcode_out = issue_op_r;

endmodule
